mdio_target_responder: RTL and testbench
========================================

Name: mdio_target_responder

Overview:
- PHY-side MDIO management target: the responder end of the MDC/MDIO link, fully synchronous to a fast system clock.
- Oversamples mdc_i/mdio_i, decodes clause 45 (or clause 22) frames, and answers reads by driving MDIO.
- Exposes a simple register-bus strobe interface to the PHY/PCS register file.
- Used in loopback benches and in soft-PHY/PCS designs where the FPGA itself is the management target.

Parameters:
- CLAUSE_45, 1, 1 = clause 45 frames (ST=00); 0 = clause 22 (ST=01).
- DATA_LENGTH, 16, width of register address and data fields.
- PREAMBLE_MIN, 32, consecutive 1 bits required before ST is accepted (1..63).
- TIMEOUT_CYCLES, 4096, clk cycles without an MDC rise before a frame is aborted (optional feature only).

Ports:
- clk  in  1  system clock; MDC must be slower than clk/8.
- reset  in  1  synchronous, active-high reset.
- mdc_i  in  1  management clock from the controller; asynchronous.
- mdio_i  in  1  MDIO pad input; asynchronous.
- mdio_o  out  1  MDIO pad output value.
- mdio_oe  out  1  MDIO pad output enable.
- phy_address  in  5  this target's port address; static.
- reg_dev_type  out  5  DEVAD (clause 45) or REGAD (clause 22) of the current access.
- reg_address  out  DATA_LENGTH  clause 45 address register (clause 22: {11'b0, REGAD}).
- reg_wr_en  out  1  one-clk write strobe.
- reg_wr_data  out  DATA_LENGTH  write data; valid while reg_wr_en=1.
- reg_rd_en  out  1  one-clk read-request strobe.
- reg_rd_data  in  DATA_LENGTH  read data from the register file.
- frame_error  out  1  one-clk pulse on an ST or TA violation.

Behaviour:
- Synchronisation and edge detection:
  - mdc_i and mdio_i each pass through a 2-flop synchroniser.
  - A third mdc flop gives a rise pulse.
  - All bit sampling uses synchronised mdio on the rise pulse.
  - Output changes occur on the clk after the rise pulse (3 clk after mdc_i rises).
- Reset values: mdio_o=0, mdio_oe=0, all strobes and frame_error=0, reg_address=0, reg_dev_type=0, reg_wr_data=0. State is HUNT, all counters 0.
- HUNT:
  - Counts consecutive 1 samples, saturating at 63; any 0 clears the count.
  - A 0 sample with count >= PREAMBLE_MIN is ST bit 0 -> ST.
- ST: the sample must equal SOF[0] (0 for clause 45, 1 for clause 22).
  - Match -> COMMAND.
  - Mismatch -> frame_error pulse, return to HUNT.
- COMMAND:
  - Shifts 12 bits: OP[1:0], PRTAD[4:0], DEVAD[4:0].
  - On the 12th sample, if PRTAD != phy_address -> IGNORE.
  - Else if OP is a read (clause 45: 11 or 10; clause 22: 10):
    - reg_dev_type <= DEVAD.
    - Pulse reg_rd_en.
    - -> TA_RD.
  - Else (write/address op) -> TA_WR.
- TA_RD:
  - Rise 1 (TA bit 1 sampled): mdio_oe=1, mdio_o=0.
  - Rise 2: latch reg_rd_data into the shift register, drive bit 15 -> TX_DATA.
  - reg_rd_data must therefore be valid within one MDC period of reg_rd_en.
- TA_WR:
  - Two samples; the second must be 0, else pulse frame_error and go to IGNORE.
  - Then -> RX_DATA.
- TX_DATA:
  - Each rise shifts out the next bit, MSB first.
  - The rise after bit 0 has been driven releases mdio_oe=0, mdio_o=0.
  - Clause 45 OP=10 (post-read-increment): reg_address += 1, wrapping 0xFFFF -> 0x0000.
  - -> HUNT.
- RX_DATA: 16 samples into the shift register, MSB first. On the 16th sample:
  - OP=00 (clause 45): reg_address <= data, no strobe.
  - OP=01: reg_wr_data <= data, reg_dev_type <= DEVAD, pulse reg_wr_en.
  - -> HUNT.
- IGNORE:
  - Counts 18 further rises (TA plus data) with mdio_oe held 0.
  - Then -> HUNT with preamble count 0.
- Bus ownership: mdio_oe is asserted only in TA_RD bit 2 and TX_DATA, never in any other state.
- Reset mid-frame: immediate return to HUNT, mdio_oe=0 on the next clk, reg_address cleared.
- Back-to-back frames: preamble counting restarts from 0 on entry to HUNT, so a new frame needs a full PREAMBLE_MIN.

Optional Feature:
- Macro: MDIO_TARGET_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every MDC rise.
  - In any state other than HUNT, reaching TIMEOUT_CYCLES forces HUNT, mdio_oe=0 and a frame_error pulse.
  - No strobe is issued for the aborted frame.
- Undefined: no counter; a stalled frame holds its state (and mdio_oe) indefinitely.

Test Plan:
- Clause 45 address then write: phy_address=5, frame 00/00/PRTAD=5/DEVAD=1/0x1234, then 00/01/5/1/0xABCD -> reg_address=0x1234, one reg_wr_en pulse with reg_wr_data=0xABCD, reg_dev_type=1.
- Read: reg_rd_data=0xA5C3, read frame to PRTAD=5 -> one reg_rd_en pulse; mdio_oe=1 from TA bit 2; bus sees 0 then 1010010111000011; mdio_oe=0 after the last bit.
- Post-read-increment: reg_address=0xFFFF, OP=10 -> data returned, then reg_address=0x0000.
- Address mismatch: frame to PRTAD=6 while phy_address=5 -> no strobes, mdio_oe stays 0, and the next valid frame is accepted.
- Short preamble / bad ST: 31 ones then a read frame -> ignored. ST=01 in clause 45 mode -> frame_error pulse, no strobes.
- Reset asserted during TX_DATA bit 7 -> mdio_oe=0 the next clk; a subsequent full read returns correct data. With MDIO_TARGET_TIMEOUT_EN, stopping MDC mid-read gives a frame_error pulse after 4096 clk.

Source files
------------

// File: rtl/mdio_target_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mdio_target_responder
//  Description : PHY-side MDIO management target. Oversamples MDC/MDIO on the
//                system clock, decodes clause 45 (or clause 22) frames, answers
//                reads by driving MDIO and strobes a simple register bus.
//                Optional build macro MDIO_TARGET_TIMEOUT_EN adds an MDC-idle
//                watchdog that aborts a stalled frame after TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_target_responder #(
    parameter int CLAUSE_45      = 1,
    parameter int DATA_LENGTH    = 16,
    parameter int PREAMBLE_MIN   = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mdc_i,
    input  logic                   mdio_i,
    output logic                   mdio_o,
    output logic                   mdio_oe,
    input  logic [4:0]             phy_address,
    output logic [4:0]             reg_dev_type,
    output logic [DATA_LENGTH-1:0] reg_address,
    output logic                   reg_wr_en,
    output logic [DATA_LENGTH-1:0] reg_wr_data,
    output logic                   reg_rd_en,
    input  logic [DATA_LENGTH-1:0] reg_rd_data,
    output logic                   frame_error
);

    // Second start-of-frame bit: 0 for clause 45 (ST=00), 1 for clause 22 (ST=01)
    localparam logic c_sof0     = (CLAUSE_45 != 0) ? 1'b0 : 1'b1;
    // Rises skipped for a frame addressed elsewhere: turnaround plus data
    localparam int   c_ign_bits = DATA_LENGTH + 2;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ST      = 3'd1,
        S_COMMAND = 3'd2,
        S_TA_RD   = 3'd3,
        S_TA_WR   = 3'd4,
        S_TX_DATA = 3'd5,
        S_RX_DATA = 3'd6,
        S_IGNORE  = 3'd7
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_cnt;
    logic [10:0]            r_cmd;
    logic [1:0]             r_op;
    logic [4:0]             r_devad;
    logic [DATA_LENGTH-1:0] r_shift;

    logic r_mdc_s1, r_mdc_s2, r_mdc_s3;
    logic r_mdio_s1, r_mdio_s2;

    logic                   w_rise;
    logic                   w_timeout;
    logic [11:0]            w_cmd;
    logic [1:0]             w_op;
    logic [4:0]             w_prtad;
    logic [4:0]             w_devad;
    logic                   w_is_read;
    logic [DATA_LENGTH-1:0] w_rx_word;

    // Two-flop synchronisers for both pads plus a third MDC flop for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdc_s1  <= 1'b0;
            r_mdc_s2  <= 1'b0;
            r_mdc_s3  <= 1'b0;
            r_mdio_s1 <= 1'b0;
            r_mdio_s2 <= 1'b0;
        end else begin
            r_mdc_s1  <= mdc_i;
            r_mdc_s2  <= r_mdc_s1;
            r_mdc_s3  <= r_mdc_s2;
            r_mdio_s1 <= mdio_i;
            r_mdio_s2 <= r_mdio_s1;
        end
    end

    assign w_rise    = r_mdc_s2 & ~r_mdc_s3;
    assign w_cmd     = {r_cmd, r_mdio_s2};
    assign w_op      = w_cmd[11:10];
    assign w_prtad   = w_cmd[9:5];
    assign w_devad   = w_cmd[4:0];
    assign w_is_read = (CLAUSE_45 != 0) ? w_op[1] : (w_op == 2'b10);
    assign w_rx_word = {r_shift[DATA_LENGTH-2:0], r_mdio_s2};

`ifdef MDIO_TARGET_TIMEOUT_EN
    localparam int c_idle_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_idle_w-1:0] r_idle;

    // Counts clk cycles since the last MDC rise while a frame is in flight
    always_ff @(posedge clk) begin
        if (reset || w_rise || (r_state == S_HUNT)) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_idle_w'(1);
        end
    end

    assign w_timeout = (r_state != S_HUNT) && !w_rise &&
                       (r_idle == c_idle_w'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Frame decoder: advances one bit per MDC rise, outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HUNT;
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_op         <= '0;
            r_devad      <= '0;
            r_shift      <= '0;
            mdio_o       <= 1'b0;
            mdio_oe      <= 1'b0;
            reg_dev_type <= '0;
            reg_address  <= '0;
            reg_wr_en    <= 1'b0;
            reg_wr_data  <= '0;
            reg_rd_en    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            frame_error <= 1'b0;
            if (w_timeout) begin
                r_state     <= S_HUNT;
                r_cnt       <= '0;
                mdio_oe     <= 1'b0;
                mdio_o      <= 1'b0;
                frame_error <= 1'b1;
            end else if (w_rise) begin
                case (r_state)
                    S_HUNT: begin
                        if (r_mdio_s2) begin
                            if (r_cnt < 8'd63) r_cnt <= r_cnt + 8'd1;
                        end else begin
                            // A zero after a long enough run of ones is ST bit 0
                            if (r_cnt >= 8'(PREAMBLE_MIN)) r_state <= S_ST;
                            r_cnt <= '0;
                        end
                    end
                    S_ST: begin
                        r_cnt <= '0;
                        if (r_mdio_s2 == c_sof0) begin
                            r_state <= S_COMMAND;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= S_HUNT;
                        end
                    end
                    S_COMMAND: begin
                        r_cmd <= w_cmd[10:0];
                        if (r_cnt == 8'd11) begin
                            r_cnt   <= '0;
                            r_op    <= w_op;
                            r_devad <= w_devad;
                            if (w_prtad != phy_address) begin
                                r_state <= S_IGNORE;
                            end else begin
                                // Clause 22 carries the register number in the DEVAD slot
                                if (CLAUSE_45 == 0) reg_address <= DATA_LENGTH'(w_devad);
                                if (w_is_read) begin
                                    reg_dev_type <= w_devad;
                                    reg_rd_en    <= 1'b1;
                                    r_state      <= S_TA_RD;
                                end else begin
                                    r_state <= S_TA_WR;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_TA_RD: begin
                        if (r_cnt == 8'd0) begin
                            // Take the bus for the second turnaround bit, driving 0
                            mdio_oe <= 1'b1;
                            mdio_o  <= 1'b0;
                            r_cnt   <= 8'd1;
                        end else begin
                            r_shift <= reg_rd_data;
                            mdio_o  <= reg_rd_data[DATA_LENGTH-1];
                            r_cnt   <= '0;
                            r_state <= S_TX_DATA;
                        end
                    end
                    S_TX_DATA: begin
                        if (r_cnt == 8'(DATA_LENGTH - 1)) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_HUNT;
                            if ((CLAUSE_45 != 0) && (r_op == 2'b10))
                                reg_address <= reg_address + DATA_LENGTH'(1);
                        end else begin
                            mdio_o  <= r_shift[DATA_LENGTH-2];
                            r_shift <= {r_shift[DATA_LENGTH-2:0], 1'b0};
                            r_cnt   <= r_cnt + 8'd1;
                        end
                    end
                    S_TA_WR: begin
                        if (r_cnt == 8'd0) begin
                            r_cnt <= 8'd1;
                        end else begin
                            r_cnt <= '0;
                            if (r_mdio_s2) begin
                                frame_error <= 1'b1;
                                r_state     <= S_IGNORE;
                            end else begin
                                r_state <= S_RX_DATA;
                            end
                        end
                    end
                    S_RX_DATA: begin
                        r_shift <= w_rx_word;
                        if (r_cnt == 8'(DATA_LENGTH - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_HUNT;
                            if ((CLAUSE_45 != 0) && (r_op == 2'b00)) begin
                                reg_address <= w_rx_word;
                            end else if (r_op == 2'b01) begin
                                reg_wr_data  <= w_rx_word;
                                reg_dev_type <= r_devad;
                                reg_wr_en    <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_IGNORE: begin
                        if (r_cnt == 8'(c_ign_bits - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_HUNT;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_HUNT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_target_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_target_responder
//  Description : Directed self-checking bench for mdio_target_responder acting
//                as an MDIO controller (MDC period 200 ns, clk period 10 ns).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_target_responder;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        mdc_i       = 1'b0;
    logic        mdio_i      = 1'b1;
    logic [4:0]  phy_address = 5'd5;
    logic [15:0] reg_rd_data = 16'h0000;
    logic        mdio_o, mdio_oe, reg_wr_en, reg_rd_en, frame_error;
    logic [4:0]  reg_dev_type;
    logic [15:0] reg_address, reg_wr_data;

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0;
    logic [15:0] last_wr_data = 16'h0;
    logic [4:0]  last_wr_dev  = 5'h0;

    // Bus level seen just before each MDC rise; index 0 = ST[1], 32 = idle bit after frame
    logic cap_oe [0:32];
    logic cap_o  [0:32];

    mdio_target_responder dut (
        .clk          (clk),
        .reset        (reset),
        .mdc_i        (mdc_i),
        .mdio_i       (mdio_i),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .phy_address  (phy_address),
        .reg_dev_type (reg_dev_type),
        .reg_address  (reg_address),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    // Strobe and bus-ownership monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (reg_wr_en) begin
            n_wr++;
            last_wr_data = reg_wr_data;
            last_wr_dev  = reg_dev_type;
        end
        if (reg_rd_en)   n_rd++;
        if (frame_error) n_err++;
        if (mdio_oe)     n_oe++;
    end

    task automatic send_bit(input logic b, input int idx);
        mdio_i = b;
        #100;
        if (idx >= 0) begin
            cap_oe[idx] = mdio_oe;
            cap_o[idx]  = mdio_o;
        end
        mdc_i = 1'b1;
        #100;
        mdc_i = 1'b0;
    endtask

    task automatic frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                         input logic [4:0] prt, input logic [4:0] dev, input logic [1:0] ta,
                         input logic [15:0] data, input int stop_after);
        logic [31:0] v;
        v = {st, op, prt, dev, ta, data};
        for (int i = 0; i < npre; i++) send_bit(1'b1, -1);
        for (int i = 0; i < 32; i++) begin
            send_bit(v[31-i], i);
            if (i == stop_after) return;
        end
        send_bit(1'b1, 32);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #100;
        checks++;
        if ({mdio_o, mdio_oe, reg_wr_en, reg_rd_en, frame_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000", {mdio_o, mdio_oe, reg_wr_en, reg_rd_en, frame_error});
        end
        checks++;
        if (reg_address !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr got %h required 0000", reg_address);
        end
        checks++;
        if (reg_dev_type !== 5'h0) begin
            errors++;
            $display("FAIL reset_dev got %h required 00", reg_dev_type);
        end
        checks++;
        if (reg_wr_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_wdata got %h required 0000", reg_wr_data);
        end
        reset = 1'b0;
        #100;
    endtask

    task automatic test_addr_write();
        int w0;
        w0 = n_wr;
        frame(32, 2'b00, 2'b00, 5'd5, 5'd1, 2'b10, 16'h1234, 99);
        checks++;
        if (reg_address !== 16'h1234) begin
            errors++;
            $display("FAIL addr_frame got %h required 1234", reg_address);
        end
        checks++;
        if (n_wr !== w0) begin
            errors++;
            $display("FAIL addr_no_strobe got %0d required %0d", n_wr, w0);
        end
        frame(32, 2'b00, 2'b01, 5'd5, 5'd1, 2'b10, 16'hABCD, 99);
        checks++;
        if (n_wr !== w0 + 1) begin
            errors++;
            $display("FAIL write_pulses got %0d required %0d", n_wr, w0 + 1);
        end
        checks++;
        if ({last_wr_dev, last_wr_data} !== {5'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL write_data got %h/%h required 01/abcd", last_wr_dev, last_wr_data);
        end
        checks++;
        if ({reg_dev_type, reg_address} !== {5'd1, 16'h1234}) begin
            errors++;
            $display("FAIL write_keeps_addr got %h/%h required 01/1234", reg_dev_type, reg_address);
        end
    endtask

    task automatic read_frame_check(input string name, input logic [1:0] op,
                                    input logic [15:0] exp_data);
        int r0;
        logic [15:0] obs_d, obs_oe;
        r0 = n_rd;
        frame(32, 2'b00, op, 5'd5, 5'd1, 2'b11, 16'hFFFF, 99);
        for (int i = 0; i < 16; i++) begin
            obs_d[15-i]  = cap_o[16+i];
            obs_oe[15-i] = cap_oe[16+i];
        end
        checks++;
        if (n_rd !== r0 + 1) begin
            errors++;
            $display("FAIL %s rd_pulses got %0d required %0d", name, n_rd, r0 + 1);
        end
        checks++;
        if ({cap_oe[14], cap_oe[15], cap_o[15]} !== 3'b010) begin
            errors++;
            $display("FAIL %s turnaround oe1/oe2/o2 got %b%b%b required 010", name, cap_oe[14], cap_oe[15], cap_o[15]);
        end
        checks++;
        if ({obs_oe, obs_d} !== {16'hFFFF, exp_data}) begin
            errors++;
            $display("FAIL %s data oe=%h bus=%h required oe=ffff bus=%h", name, obs_oe, obs_d, exp_data);
        end
        checks++;
        if (cap_oe[32] !== 1'b0) begin
            errors++;
            $display("FAIL %s release got oe=%b required 0", name, cap_oe[32]);
        end
    endtask

    task automatic test_read();
        reg_rd_data = 16'hA5C3;
        send_bit(1'b0, -1);
        read_frame_check("read", 2'b11, 16'hA5C3);
        checks++;
        if ({reg_dev_type, reg_address} !== {5'd1, 16'h1234}) begin
            errors++;
            $display("FAIL read_no_inc got %h/%h required 01/1234", reg_dev_type, reg_address);
        end
    endtask

    task automatic test_post_inc();
        frame(32, 2'b00, 2'b00, 5'd5, 5'd1, 2'b10, 16'hFFFF, 99);
        reg_rd_data = 16'h3C5A;
        read_frame_check("postinc", 2'b10, 16'h3C5A);
        checks++;
        if (reg_address !== 16'h0000) begin
            errors++;
            $display("FAIL postinc_wrap got %h required 0000", reg_address);
        end
    endtask

    task automatic test_addr_mismatch();
        int w0, r0, o0;
        w0 = n_wr; r0 = n_rd; o0 = n_oe;
        frame(32, 2'b00, 2'b01, 5'd6, 5'd1, 2'b10, 16'hBEEF, 99);
        frame(32, 2'b00, 2'b11, 5'd6, 5'd1, 2'b11, 16'hFFFF, 99);
        checks++;
        if ({n_wr, n_rd, n_oe} !== {w0, r0, o0}) begin
            errors++;
            $display("FAIL mismatch_quiet got wr=%0d rd=%0d oe=%0d required %0d %0d %0d", n_wr, n_rd, n_oe, w0, r0, o0);
        end
        frame(32, 2'b00, 2'b01, 5'd5, 5'd2, 2'b10, 16'h5555, 99);
        checks++;
        if ({n_wr, last_wr_dev, last_wr_data} !== {w0 + 1, 5'd2, 16'h5555}) begin
            errors++;
            $display("FAIL mismatch_next got wr=%0d dev=%h data=%h required %0d 02 5555", n_wr, last_wr_dev, last_wr_data, w0 + 1);
        end
    endtask

    task automatic test_bad_preamble_st();
        int r0, o0, e0, w0;
        r0 = n_rd; o0 = n_oe; e0 = n_err; w0 = n_wr;
        send_bit(1'b0, -1);
        frame(31, 2'b00, 2'b11, 5'd5, 5'd1, 2'b11, 16'hFFFF, 99);
        checks++;
        if ({n_rd, n_oe, n_err} !== {r0, o0, e0}) begin
            errors++;
            $display("FAIL short_preamble got rd=%0d oe=%0d err=%0d required %0d %0d %0d", n_rd, n_oe, n_err, r0, o0, e0);
        end
        frame(32, 2'b01, 2'b11, 5'd5, 5'd1, 2'b11, 16'hFFFF, 99);
        checks++;
        if (n_err !== e0 + 1) begin
            errors++;
            $display("FAIL bad_st_error got %0d required %0d", n_err, e0 + 1);
        end
        checks++;
        if ({n_rd, n_wr, n_oe} !== {r0, w0, o0}) begin
            errors++;
            $display("FAIL bad_st_quiet got rd=%0d wr=%0d oe=%0d required %0d %0d %0d", n_rd, n_wr, n_oe, r0, w0, o0);
        end
    endtask

    task automatic test_reset_mid_tx();
        frame(32, 2'b00, 2'b00, 5'd5, 5'd1, 2'b10, 16'h0F0F, 99);
        reg_rd_data = 16'h1357;
        frame(32, 2'b00, 2'b11, 5'd5, 5'd1, 2'b11, 16'hFFFF, 24);
        checks++;
        if (mdio_oe !== 1'b1) begin
            errors++;
            $display("FAIL midtx_driving got oe=%b required 1", mdio_oe);
        end
        reset = 1'b1;
        #10;
        checks++;
        if ({mdio_oe, reg_address} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midtx_reset got oe=%b addr=%h required 0 0000", mdio_oe, reg_address);
        end
        #90;
        reset = 1'b0;
        #100;
        read_frame_check("after_reset", 2'b11, 16'h1357);
    endtask

`ifdef MDIO_TARGET_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        reg_rd_data = 16'hFFFF;
        e0 = n_err;
        frame(32, 2'b00, 2'b11, 5'd5, 5'd1, 2'b11, 16'hFFFF, 20);
        #40000;
        checks++;
        if (n_err !== e0) begin
            errors++;
            $display("FAIL timeout_early got %0d required %0d", n_err, e0);
        end
        #1200;
        checks++;
        if ({n_err, mdio_oe} !== {e0 + 1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_abort got err=%0d oe=%b required %0d 0", n_err, mdio_oe, e0 + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addr_write();
        test_read();
        test_post_inc();
        test_addr_mismatch();
        test_bad_preamble_st();
        test_reset_mid_tx();
`ifdef MDIO_TARGET_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
